// File: rtl/ie_interrupt_handler_pkg.sv
// Shared definitions for the 6502 interrupt/exception sequencer: vectors, stack page,
// status flag positions and the handler state/service encodings.
package ie_defs;

    localparam logic [15:0] VEC_NMI    = 16'hFFFA;
    localparam logic [15:0] VEC_RESET  = 16'hFFFC;
    localparam logic [15:0] VEC_BRK    = 16'hFFFE;
    localparam logic [7:0]  STACK_PAGE = 8'h01;

    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_I = 2;
    localparam int FLAG_D = 3;
    localparam int FLAG_B = 4;
    localparam int FLAG_U = 5;
    localparam int FLAG_V = 6;
    localparam int FLAG_N = 7;

    localparam logic [7:0] MASK_I = 8'(1 << FLAG_I);
    localparam logic [7:0] MASK_B = 8'(1 << FLAG_B);
    localparam logic [7:0] MASK_U = 8'(1 << FLAG_U);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PUSH_PCH,
        ST_PUSH_PCL,
        ST_PUSH_P,
        ST_RD_WAIT,
        ST_RD_CAP
    } ih_state_t;

    typedef enum logic [2:0] {
        SVC_NONE,
        SVC_RESET,
        SVC_RTI,
        SVC_BRK,
        SVC_NMI
    } ih_svc_t;

    function automatic logic [15:0] stack_addr(input logic [7:0] sp);
        return {STACK_PAGE, sp};
    endfunction

endpackage

// File: rtl/ih_edge_latch.sv
// Rising-edge detector feeding a sticky pending flag; a new edge wins over a clear
// arriving on the same cycle so an event during service is never lost.
module ih_edge_latch (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    input  logic clear,
    output logic pending
);

    logic sig_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sig_q   <= 1'b0;
            pending <= 1'b0;
        end else begin
            sig_q <= sig;
            if (sig && !sig_q)
                pending <= 1'b1;
            else if (clear)
                pending <= 1'b0;
        end
    end

endmodule

// File: rtl/ie_interrupt_handler.sv
// Post-instruction interrupt sequencer: soft reset, RTI, BRK and (with IH_NMI_EN defined)
// PPU vblank NMI, driving stack pushes/pulls and vector fetches over the CPU bus.
module ie_interrupt_handler
    import ie_defs::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] mem_addr,
    input  logic [7:0]  mem_data_in,
    output logic [7:0]  mem_data_out,
    output logic        mem_write_en,
    input  logic        is_break,
    input  logic [7:0]  ppu_status,
    input  logic        soft_reset,
    input  logic        is_rti,
    input  logic        int_start,
    output logic        int_done,
    output logic        int_busy,
    input  logic [15:0] pc_in,
    input  logic [7:0]  status_in,
    input  logic [7:0]  sp_in,
    output logic [15:0] pc_out,
    output logic [7:0]  status_out,
    output logic [7:0]  sp_out
);

    ih_state_t   state;
    ih_svc_t     svc;
    ih_svc_t     svc_sel;
    logic [1:0]  rd_step;
    logic [15:0] lat_pc;
    logic [7:0]  lat_p;
    logic [7:0]  lat_sp;
    logic [7:0]  tmp_p;
    logic [7:0]  tmp_lo;
    logic [7:0]  push_p;
    logic        accept;
    logic        soft_pend;
    logic        nmi_pend;
    logic        soft_clear;
    logic        unused_ppu;

    assign accept     = (state == ST_IDLE) && int_start;
    assign soft_clear = accept && (svc_sel == SVC_RESET);
    assign push_p     = (lat_p & ~MASK_B) | MASK_U | ((svc == SVC_BRK) ? MASK_B : 8'h00);

    ih_edge_latch u_soft_latch (
        .clk     (clk),
        .rst     (rst),
        .sig     (soft_reset),
        .clear   (soft_clear),
        .pending (soft_pend)
    );

`ifdef IH_NMI_EN
    logic nmi_clear;
    assign nmi_clear  = accept && (svc_sel == SVC_NMI);
    assign unused_ppu = ^ppu_status[6:0];

    ih_edge_latch u_nmi_latch (
        .clk     (clk),
        .rst     (rst),
        .sig     (ppu_status[7]),
        .clear   (nmi_clear),
        .pending (nmi_pend)
    );
`else
    assign nmi_pend   = 1'b0;
    assign unused_ppu = ^ppu_status;
`endif

    always_comb begin
        svc_sel = SVC_NONE;
        if (soft_pend)
            svc_sel = SVC_RESET;
        else if (is_rti)
            svc_sel = SVC_RTI;
        else if (is_break)
            svc_sel = SVC_BRK;
        else if (nmi_pend)
            svc_sel = SVC_NMI;
    end

    // Each read holds its address for two cycles; data is captured on the second edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            svc          <= SVC_NONE;
            rd_step      <= 2'd0;
            lat_pc       <= 16'h0000;
            lat_p        <= 8'h00;
            lat_sp       <= 8'h00;
            tmp_p        <= 8'h00;
            tmp_lo       <= 8'h00;
            mem_addr     <= 16'h0000;
            mem_data_out <= 8'h00;
            mem_write_en <= 1'b0;
            int_done     <= 1'b0;
            int_busy     <= 1'b0;
            pc_out       <= 16'h0000;
            status_out   <= 8'h00;
            sp_out       <= 8'hFF;
        end else begin
            mem_write_en <= 1'b0;
            mem_data_out <= 8'h00;
            case (state)
                ST_IDLE: begin
                    if (int_start) begin
                        lat_pc   <= pc_in;
                        lat_p    <= status_in;
                        lat_sp   <= sp_in;
                        svc      <= svc_sel;
                        rd_step  <= 2'd0;
                        int_done <= 1'b0;
                        case (svc_sel)
                            SVC_NONE: begin
                                int_done   <= 1'b1;
                                pc_out     <= pc_in;
                                status_out <= status_in;
                                sp_out     <= sp_in;
                            end
                            SVC_RESET: begin
                                int_busy <= 1'b1;
                                mem_addr <= VEC_RESET;
                                state    <= ST_RD_WAIT;
                            end
                            SVC_RTI: begin
                                int_busy <= 1'b1;
                                mem_addr <= stack_addr(sp_in + 8'd1);
                                state    <= ST_RD_WAIT;
                            end
                            default: begin
                                int_busy     <= 1'b1;
                                mem_addr     <= stack_addr(sp_in);
                                mem_data_out <= pc_in[15:8];
                                mem_write_en <= 1'b1;
                                state        <= ST_PUSH_PCH;
                            end
                        endcase
                    end
                end
                ST_PUSH_PCH: begin
                    mem_addr     <= stack_addr(lat_sp - 8'd1);
                    mem_data_out <= lat_pc[7:0];
                    mem_write_en <= 1'b1;
                    state        <= ST_PUSH_PCL;
                end
                ST_PUSH_PCL: begin
                    mem_addr     <= stack_addr(lat_sp - 8'd2);
                    mem_data_out <= push_p;
                    mem_write_en <= 1'b1;
                    state        <= ST_PUSH_P;
                end
                ST_PUSH_P: begin
                    mem_addr <= (svc == SVC_BRK) ? VEC_BRK : VEC_NMI;
                    state    <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    state <= ST_RD_CAP;
                end
                ST_RD_CAP: begin
                    state   <= ST_RD_WAIT;
                    rd_step <= rd_step + 2'd1;
                    if (svc == SVC_RTI) begin
                        case (rd_step)
                            2'd0: begin
                                tmp_p    <= mem_data_in;
                                mem_addr <= stack_addr(lat_sp + 8'd2);
                            end
                            2'd1: begin
                                tmp_lo   <= mem_data_in;
                                mem_addr <= stack_addr(lat_sp + 8'd3);
                            end
                            default: begin
                                pc_out     <= {mem_data_in, tmp_lo};
                                status_out <= (tmp_p & ~MASK_B) | MASK_U;
                                sp_out     <= lat_sp + 8'd3;
                                int_done   <= 1'b1;
                                int_busy   <= 1'b0;
                                state      <= ST_IDLE;
                            end
                        endcase
                    end else if (rd_step == 2'd0) begin
                        tmp_lo   <= mem_data_in;
                        mem_addr <= mem_addr + 16'd1;
                    end else begin
                        pc_out     <= {mem_data_in, tmp_lo};
                        status_out <= lat_p | MASK_I;
                        sp_out     <= lat_sp - 8'd3;
                        int_done   <= 1'b1;
                        int_busy   <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ie_interrupt_handler.sv
// Bench for ie_interrupt_handler: directed scenarios with literal expectations, then randomized
// service requests checked every cycle against a transaction-level model (IH_NMI_EN aware).
module tb_ie_interrupt_handler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data_in = 8'h00;
    logic [7:0]  mem_data_out;
    logic        mem_write_en;
    logic        is_break = 1'b0;
    logic [7:0]  ppu_status = 8'h00;
    logic        soft_reset = 1'b0;
    logic        is_rti = 1'b0;
    logic        int_start = 1'b0;
    logic        int_done;
    logic        int_busy;
    logic [15:0] pc_in = 16'h0000;
    logic [7:0]  status_in = 8'h00;
    logic [7:0]  sp_in = 8'h00;
    logic [15:0] pc_out;
    logic [7:0]  status_out;
    logic [7:0]  sp_out;

    int total = 0;
    int bad = 0;

`ifdef IH_NMI_EN
    localparam bit NMI_EN = 1'b1;
`else
    localparam bit NMI_EN = 1'b0;
`endif

    logic [7:0] mem [0:65535];
    logic [7:0] rd_stage = 8'h00;

    // Transaction-level model state
    bit          m_started = 1'b0;
    int          m_n = 0;
    int          m_len = 0;
    int          m_wr = 0;
    logic [15:0] m_pc = 16'h0000;
    logic [7:0]  m_p = 8'h00;
    logic [7:0]  m_sp = 8'h00;
    logic [7:0]  m_wsp = 8'h00;
    logic [7:0]  m_push [3];
    bit          m_soft_pend = 1'b0;
    bit          m_nmi_pend = 1'b0;
    bit          m_soft_prev = 1'b0;
    bit          m_nmi_prev = 1'b0;

    ie_interrupt_handler dut (
        .clk          (clk),
        .rst          (rst),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .mem_write_en (mem_write_en),
        .is_break     (is_break),
        .ppu_status   (ppu_status),
        .soft_reset   (soft_reset),
        .is_rti       (is_rti),
        .int_start    (int_start),
        .int_done     (int_done),
        .int_busy     (int_busy),
        .pc_in        (pc_in),
        .status_in    (status_in),
        .sp_in        (sp_in),
        .pc_out       (pc_out),
        .status_out   (status_out),
        .sp_out       (sp_out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Memory with two-cycle read latency, model update and per-cycle comparison.
    always @(posedge clk) begin
        bit         idle;
        bit         rise_s;
        bit         rise_n;
        bit         clr_s;
        bit         clr_n;
        logic [7:0] s1;
        logic [7:0] s2;
        logic [7:0] s3;
        logic [7:0] wa;
        #1;
        mem_data_in = rd_stage;
        rd_stage    = mem[mem_addr];
        if (!rst) begin
            m_started   = 1'b0;
            m_n         = 0;
            m_len       = 0;
            m_wr        = 0;
            m_soft_pend = 1'b0;
            m_nmi_pend  = 1'b0;
            m_soft_prev = 1'b0;
            m_nmi_prev  = 1'b0;
        end else begin
            idle   = !m_started || (m_n > m_len);
            rise_s = soft_reset && !m_soft_prev;
            rise_n = NMI_EN && ppu_status[7] && !m_nmi_prev;
            clr_s  = 1'b0;
            clr_n  = 1'b0;
            if (int_start && idle) begin
                m_started = 1'b1;
                m_n       = 1;
                m_wr      = 0;
                m_wsp     = sp_in;
                if (m_soft_pend) begin
                    clr_s = 1'b1;
                    m_len = 4;
                    m_pc  = {mem[16'hFFFD], mem[16'hFFFC]};
                    m_p   = status_in | 8'h04;
                    m_sp  = sp_in - 8'd3;
                end else if (is_rti) begin
                    s1    = sp_in + 8'd1;
                    s2    = sp_in + 8'd2;
                    s3    = sp_in + 8'd3;
                    m_len = 6;
                    m_p   = (mem[{8'h01, s1}] & 8'hEF) | 8'h20;
                    m_pc  = {mem[{8'h01, s3}], mem[{8'h01, s2}]};
                    m_sp  = s3;
                end else if (is_break || m_nmi_pend) begin
                    clr_n     = !is_break;
                    m_len     = 7;
                    m_wr      = 3;
                    m_push[0] = pc_in[15:8];
                    m_push[1] = pc_in[7:0];
                    m_push[2] = {status_in[7:6], 1'b1, is_break, status_in[3:0]};
                    m_pc      = is_break ? {mem[16'hFFFF], mem[16'hFFFE]}
                                         : {mem[16'hFFFB], mem[16'hFFFA]};
                    m_p       = status_in | 8'h04;
                    m_sp      = sp_in - 8'd3;
                end else begin
                    m_len = 0;
                    m_pc  = pc_in;
                    m_p   = status_in;
                    m_sp  = sp_in;
                end
            end else if (m_started && m_n < 1000) begin
                m_n++;
            end
            m_soft_pend = rise_s || (m_soft_pend && !clr_s);
            m_nmi_pend  = rise_n || (m_nmi_pend && !clr_n);
            m_soft_prev = soft_reset;
            m_nmi_prev  = ppu_status[7];

            checkOutput("busy", 32'(int_busy), 32'(m_started && m_n <= m_len));
            checkOutput("done", 32'(int_done), 32'(m_started && m_n > m_len));
            checkOutput("write_en", 32'(mem_write_en), 32'(m_started && m_n <= m_wr));
            if (mem_write_en && m_started && m_n <= m_wr) begin
                wa = m_wsp - 8'(m_n - 1);
                checkOutput("write_addr", 32'(mem_addr), 32'({8'h01, wa}));
                checkOutput("write_data", 32'(mem_data_out), 32'(m_push[m_n-1]));
            end
            if (m_started && m_n > m_len) begin
                checkOutput("pc_out", 32'(pc_out), 32'(m_pc));
                checkOutput("status_out", 32'(status_out), 32'(m_p));
                checkOutput("sp_out", 32'(sp_out), 32'(m_sp));
            end else if (!m_started) begin
                checkOutput("idle_pc_out", 32'(pc_out), 'h0);
                checkOutput("idle_status_out", 32'(status_out), 'h0);
                checkOutput("idle_sp_out", 32'(sp_out), 'hFF);
            end
            if (mem_write_en)
                mem[mem_addr] = mem_data_out;
        end
    end

    task automatic applyStimulus(input logic brk, input logic rti, input logic [15:0] pc,
                                 input logic [7:0] p, input logic [7:0] sp, input bit noisy);
        @(negedge clk);
        if (noisy) begin
            soft_reset = ($urandom_range(0, 9) == 0);
            ppu_status = 8'($urandom);
        end
        is_break  = brk;
        is_rti    = rti;
        pc_in     = pc;
        status_in = p;
        sp_in     = sp;
        int_start = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            int_start = 1'b0;
            if (int_done && !int_busy)
                return;
            if (noisy) begin
                is_break   = 1'($urandom);
                is_rti     = 1'($urandom);
                pc_in      = 16'($urandom);
                status_in  = 8'($urandom);
                sp_in      = 8'($urandom);
                soft_reset = ($urandom_range(0, 9) == 0);
                if ($urandom_range(0, 3) == 0)
                    ppu_status = 8'($urandom);
                int_start  = ($urandom_range(0, 5) == 0);
            end
        end
        total++;
        bad++;
        $display("[TB] FAIL timeout: actual=no_done required=done within 40 cycles");
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 65536; i++)
            mem[i] = 8'($urandom);

        repeat (3) @(negedge clk);
        checkOutput("reset_sp_out", 32'(sp_out), 'hFF);
        checkOutput("reset_pc_out", 32'(pc_out), 'h0);
        checkOutput("reset_write_en", 32'(mem_write_en), 'h0);
        checkOutput("reset_done", 32'(int_done), 'h0);
        rst = 1'b1;
        @(negedge clk);

        // Nothing pending: immediate pass-through
        applyStimulus(1'b0, 1'b0, 16'hC123, 8'h00, 8'hFD, 1'b0);
        checkOutput("t1_done", 32'(int_done), 'h1);
        checkOutput("t1_pc", 32'(pc_out), 'hC123);

        // BRK
        mem[16'hFFFE] = 8'h00;
        mem[16'hFFFF] = 8'h90;
        applyStimulus(1'b1, 1'b0, 16'h8002, 8'h01, 8'hFD, 1'b0);
        checkOutput("t2_push_pch", 32'(mem[16'h01FD]), 'h80);
        checkOutput("t2_push_pcl", 32'(mem[16'h01FC]), 'h02);
        checkOutput("t2_push_p", 32'(mem[16'h01FB]), 'h31);
        checkOutput("t2_pc", 32'(pc_out), 'h9000);
        checkOutput("t2_status", 32'(status_out), 'h05);
        checkOutput("t2_sp", 32'(sp_out), 'hFA);

        // RTI returns from the frame just pushed
        applyStimulus(1'b0, 1'b1, 16'h1234, 8'hFF, 8'hFA, 1'b0);
        checkOutput("t3_pc", 32'(pc_out), 'h8002);
        checkOutput("t3_status", 32'(status_out), 'h21);
        checkOutput("t3_sp", 32'(sp_out), 'hFD);

        // Vblank edge then start
        mem[16'hFFFA] = 8'h10;
        mem[16'hFFFB] = 8'hE0;
        ppu_status = 8'h80;
        repeat (2) @(negedge clk);
        applyStimulus(1'b0, 1'b0, 16'hC000, 8'h00, 8'hFD, 1'b0);
`ifdef IH_NMI_EN
        checkOutput("t4_pc", 32'(pc_out), 'hE010);
        checkOutput("t4_status", 32'(status_out), 'h04);
        checkOutput("t4_sp", 32'(sp_out), 'hFA);
        checkOutput("t4_push_p", 32'(mem[16'h01FB]), 'h20);
        checkOutput("t4_push_pch", 32'(mem[16'h01FD]), 'hC0);
`else
        checkOutput("t4_pc", 32'(pc_out), 'hC000);
        checkOutput("t4_status", 32'(status_out), 'h00);
        checkOutput("t4_sp", 32'(sp_out), 'hFD);
`endif
        applyStimulus(1'b0, 1'b0, 16'h4321, 8'h81, 8'h10, 1'b0);
        checkOutput("t4b_pc", 32'(pc_out), 'h4321);
        checkOutput("t4b_sp", 32'(sp_out), 'h10);

        // Soft reset and NMI both pending; soft reset outranks BRK too
        mem[16'hFFFC] = 8'h00;
        mem[16'hFFFD] = 8'hC0;
        @(negedge clk);
        ppu_status = 8'h00;
        soft_reset = 1'b1;
        @(negedge clk);
        soft_reset = 1'b0;
        ppu_status = 8'h80;
        repeat (2) @(negedge clk);
        applyStimulus(1'b1, 1'b0, 16'h5555, 8'h00, 8'h40, 1'b0);
        checkOutput("t5_pc", 32'(pc_out), 'hC000);
        checkOutput("t5_status", 32'(status_out), 'h04);
        checkOutput("t5_sp", 32'(sp_out), 'h3D);
        applyStimulus(1'b0, 1'b0, 16'h6000, 8'h01, 8'h3D, 1'b0);
`ifdef IH_NMI_EN
        checkOutput("t5b_pc", 32'(pc_out), 'hE010);
        checkOutput("t5b_status", 32'(status_out), 'h05);
        checkOutput("t5b_sp", 32'(sp_out), 'h3A);
`else
        checkOutput("t5b_pc", 32'(pc_out), 'h6000);
        checkOutput("t5b_status", 32'(status_out), 'h01);
        checkOutput("t5b_sp", 32'(sp_out), 'h3D);
`endif

        // Asynchronous reset in the middle of a BRK push sequence
        @(negedge clk);
        ppu_status = 8'h00;
        is_break   = 1'b1;
        pc_in      = 16'hABCD;
        status_in  = 8'h00;
        sp_in      = 8'hFD;
        int_start  = 1'b1;
        @(negedge clk);
        int_start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("t6_write_en", 32'(mem_write_en), 'h0);
        checkOutput("t6_sp", 32'(sp_out), 'hFF);
        checkOutput("t6_busy", 32'(int_busy), 'h0);
        checkOutput("t6_done", 32'(int_done), 'h0);
        checkOutput("t6_pc", 32'(pc_out), 'h0);
        repeat (2) @(negedge clk);
        is_break = 1'b0;
        rst = 1'b1;
        @(negedge clk);

        // Randomized requests with noise on edges, flags and stray starts
        for (int t = 0; t < 150; t++) begin
            for (int v = 16'hFFFA; v <= 16'hFFFF; v++)
                mem[v] = 8'($urandom);
            mem[{8'h01, 8'($urandom)}] = 8'($urandom);
            applyStimulus(($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
                          16'($urandom), 8'($urandom), 8'($urandom), 1'b1);
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
